// File: rtl/amm_arb_pkg.sv
// amm_arb_pkg: shared types and helpers for the Avalon-MM many-to-one arbiter.
// Holds the FSM state enum, width helpers and the arbitration pick functions.
package amm_arb_pkg;

    // Arbiter FSM: ARB picks a winner, OWN forwards that master to the slave.
    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } state_t;

    // Widest request vector the pick functions accept.
    localparam int MAX_MST = 32;

    // Index width for n items; never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Counter width able to hold the values 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Round-robin pick: the first requester found searching from last+1 upward,
    // wrapping at n. The descending loop lets the nearest candidate assign last.
    function automatic int rr_pick(input logic [MAX_MST-1:0] req, input int n, input int last);
        int pick;
        pick = last;
        for (int k = MAX_MST; k >= 1; k--) begin
            if (k <= n) begin
                if (req[(last + k) % n]) pick = (last + k) % n;
            end
        end
        return pick;
    endfunction

    // Fixed-priority pick: the lowest requesting index wins.
    function automatic int fixed_pick(input logic [MAX_MST-1:0] req, input int n);
        int pick;
        pick = 0;
        for (int k = MAX_MST - 1; k >= 0; k--) begin
            if (k < n) begin
                if (req[k]) pick = k;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/avalon_mm_if.sv
// avalon_mm_if: minimal Avalon-MM bundle with pipelined reads (readdatavalid).
// Use the master modport on the side that issues commands and the slave modport
// on the side that answers them.
interface avalon_mm_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] address;
    logic              write;
    logic              read;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;
    logic              waitrequest;

    modport master (
        output address, write, read, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, write, read, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/amm_arb_resp_fifo.sv
// amm_arb_resp_fifo: owner FIFO for outstanding reads. Each entry is the index
// of the master that issued a read. The head tells the arbiter which master the
// next readdatavalid beat belongs to. A push and a pop in the same cycle are
// both honoured. A push while full and a pop while empty are ignored.
module amm_arb_resp_fifo
    import amm_arb_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int PTR_W = idx_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // Advance a pointer with an explicit wrap, so any depth works.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer and occupancy bookkeeping.
    // NOTE: registers take non-blocking assignments so that every flop samples
    // values from before the clock edge, whatever order the statements are in.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage.
    // NOTE: storage has no reset. The empty count already marks every entry
    // invalid, so resetting the array would only add reset fan-out.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/amm_arbiter.sv
// amm_arbiter: MST_CNT Avalon-MM masters share one slave port.
// The arbiter decides once per transaction and takes two cycles per transfer
// (ARB, then OWN). Read ownership is queued in amm_arb_resp_fifo, so each
// readdatavalid beat goes back to the master that issued the read.
// Build option: define AMM_ARB_FIXED_PRIO_EN for fixed priority, where the
// lowest index wins. Without it, arbitration is round-robin.
module amm_arbiter
    import amm_arb_pkg::*;
#(
    parameter int MST_CNT     = 2,
    parameter int MAX_PENDING = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 16
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    avalon_mm_if.slave    mst_mem_if [MST_CNT],
    avalon_mm_if.master   slv_mem_if
);
    localparam int IDX_W = idx_width(MST_CNT);

    // Flattened master-side command signals.
    logic [ADDR_W-1:0]  w_m_addr  [MST_CNT];
    logic [DATA_W-1:0]  w_m_wdata [MST_CNT];
    logic [MST_CNT-1:0] w_m_rd;
    logic [MST_CNT-1:0] w_m_wr;
    logic [MST_CNT-1:0] w_req;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_grant_idx;
    logic [IDX_W-1:0]   w_grant_nxt;
    logic [IDX_W-1:0]   w_pick;
`ifndef AMM_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   r_last_grant;
    logic [IDX_W-1:0]   w_last_nxt;
`endif

    logic               w_g_rd;
    logic               w_g_wr;
    logic               w_g_wait;
    logic               w_slv_rd;
    logic               w_slv_wr;
    logic               w_accept_rd;

    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [IDX_W-1:0]   w_head;
    logic               w_rdv_hit;
    logic               r_err;

    // Per-master wiring. Commands come in. readdata is broadcast to every master.
    // readdatavalid goes only to the master at the FIFO head. Waitrequest is low
    // only for the master that owns the slave port.
    for (genvar gi = 0; gi < MST_CNT; gi++) begin : g_mst
        assign w_m_addr[gi]  = mst_mem_if[gi].address;
        assign w_m_wdata[gi] = mst_mem_if[gi].writedata;
        assign w_m_rd[gi]    = mst_mem_if[gi].read;
        assign w_m_wr[gi]    = mst_mem_if[gi].write;
        assign w_req[gi]     = w_m_rd[gi] | w_m_wr[gi];

        assign mst_mem_if[gi].readdata      = slv_mem_if.readdata;
        assign mst_mem_if[gi].readdatavalid = w_rdv_hit & (w_head == IDX_W'(gi));
        assign mst_mem_if[gi].waitrequest   =
            ((r_state == OWN) && (r_grant_idx == IDX_W'(gi))) ? w_g_wait : 1'b1;
    end

    // Arbitration winner for the next ARB decision.
`ifdef AMM_ARB_FIXED_PRIO_EN
    assign w_pick = IDX_W'(fixed_pick(MAX_MST'(w_req), MST_CNT));
`else
    assign w_pick = IDX_W'(rr_pick(MAX_MST'(w_req), MST_CNT, int'(r_last_grant)));
`endif

    // Slave command is routed from the granted master. read/write are gated by the FSM.
    assign slv_mem_if.address   = w_m_addr[r_grant_idx];
    assign slv_mem_if.writedata = w_m_wdata[r_grant_idx];
    assign slv_mem_if.read      = w_slv_rd;
    assign slv_mem_if.write     = w_slv_wr;

    // Response beats are routed only when an owner is known. Otherwise they are dropped.
    assign w_rdv_hit = slv_mem_if.readdatavalid & ~w_fifo_empty;

    // Next-state, grant and slave command decode.
    // NOTE: every variable written here gets a default value first, so no
    // path through the block can leave a value held, and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_idx;
`ifndef AMM_ARB_FIXED_PRIO_EN
        w_last_nxt  = r_last_grant;
`endif
        w_slv_rd    = 1'b0;
        w_slv_wr    = 1'b0;
        w_g_wait    = 1'b1;
        w_accept_rd = 1'b0;
        // Read wins when a master asserts read and write together.
        w_g_rd      = w_m_rd[r_grant_idx];
        w_g_wr      = w_m_wr[r_grant_idx] & ~w_m_rd[r_grant_idx];

        case (r_state)
            ARB: begin
                if (|w_req) begin
                    w_grant_nxt = w_pick;
                    w_state_nxt = OWN;
                end
            end
            OWN: begin
                // A read stalls while the owner FIFO is full. Writes proceed.
                w_slv_rd    = w_g_rd & ~w_fifo_full;
                w_slv_wr    = w_g_wr;
                w_g_wait    = (w_g_rd & w_fifo_full) | slv_mem_if.waitrequest;
                w_accept_rd = w_slv_rd & ~slv_mem_if.waitrequest;
                if (!(w_g_rd | w_g_wr)) begin
                    // The owner withdrew its request: give up the port with no transfer.
                    w_state_nxt = ARB;
                end else if ((w_slv_rd | w_slv_wr) & ~slv_mem_if.waitrequest) begin
                    w_state_nxt = ARB;
`ifndef AMM_ARB_FIXED_PRIO_EN
                    w_last_nxt  = r_grant_idx;
`endif
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    // FSM state, grant and round-robin pointer registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state      <= ARB;
            r_grant_idx  <= '0;
`ifndef AMM_ARB_FIXED_PRIO_EN
            r_last_grant <= IDX_W'(MST_CNT - 1);
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_grant_idx  <= w_grant_nxt;
`ifndef AMM_ARB_FIXED_PRIO_EN
            r_last_grant <= w_last_nxt;
`endif
        end
    end

    // Sticky flag: a readdatavalid beat arrived while no read was outstanding.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) r_err <= 1'b0;
        else          r_err <= r_err | (slv_mem_if.readdatavalid & w_fifo_empty);
    end

    amm_arb_resp_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_PENDING)
    ) u_resp_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .i_push      (w_accept_rd),
        .i_push_data (r_grant_idx),
        .i_pop       (w_rdv_hit),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_head      (w_head)
    );

endmodule

// File: tb/tb_amm_arbiter.sv
// tb_amm_arbiter: directed bench for amm_arbiter with two masters and a
// four-deep owner FIFO. Inputs change 1 ns after the rising edge. Outputs are
// sampled on the falling edge. Expected grants follow AMM_ARB_FIXED_PRIO_EN.
module tb_amm_arbiter;
    import amm_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   exp_g [4];

    always #5 clk = ~clk;

    avalon_mm_if #(.ADDR_W(32), .DATA_W(16)) m_if [2] ();
    avalon_mm_if #(.ADDR_W(32), .DATA_W(16)) s_if ();

    amm_arbiter #(
        .MST_CNT     (2),
        .MAX_PENDING (4),
        .ADDR_W      (32),
        .DATA_W      (16)
    ) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .mst_mem_if (m_if),
        .slv_mem_if (s_if)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef AMM_ARB_FIXED_PRIO_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{1, 0, 1, 0};
`endif
        rst_n = 1'b0;
        m_if[0].address = '0; m_if[0].writedata = '0; m_if[0].read = 1'b0; m_if[0].write = 1'b0;
        m_if[1].address = '0; m_if[1].writedata = '0; m_if[1].read = 1'b0; m_if[1].write = 1'b0;
        s_if.waitrequest = 1'b0; s_if.readdata = '0; s_if.readdatavalid = 1'b0;

        // Reset values
        settle();
        check("rst_slv_read",  s_if.read, 0);
        check("rst_slv_write", s_if.write, 0);
        check("rst_m0_wait",   m_if[0].waitrequest, 1);
        check("rst_m1_wait",   m_if[1].waitrequest, 1);
        check("rst_m0_rdv",    m_if[0].readdatavalid, 0);
        check("rst_m1_rdv",    m_if[1].readdatavalid, 0);
        check("rst_err",       dut.r_err, 0);
        tick();
        rst_n = 1'b1;

        // 1: single master write, reaches slave one cycle after request
        tick();
        m_if[0].write = 1'b1; m_if[0].address = 32'h10; m_if[0].writedata = 16'h1234;
        settle();
        check("t1_arb_write", s_if.write, 0);
        check("t1_arb_m0_wait", m_if[0].waitrequest, 1);
        tick();
        settle();
        check("t1_own_write", s_if.write, 1);
        check("t1_own_addr",  s_if.address, 32'h10);
        check("t1_own_data",  s_if.writedata, 16'h1234);
        check("t1_own_m0_wait", m_if[0].waitrequest, 0);
        check("t1_own_m1_wait", m_if[1].waitrequest, 1);
        tick();
        m_if[0].write = 1'b0;
        settle();
        check("t1_back_arb_write", s_if.write, 0);
        check("t1_back_arb_m0_wait", m_if[0].waitrequest, 1);

        // 2: both masters read continuously, grant order then return routing
        tick();
        m_if[0].read = 1'b1; m_if[0].address = 32'h100;
        m_if[1].read = 1'b1; m_if[1].address = 32'h200;
        settle();
        check("t2_arb_read", s_if.read, 0);
        for (int k = 0; k < 4; k++) begin
            tick();
            settle();
            check("t2_own_read", s_if.read, 1);
            check("t2_grant_addr", s_if.address, (exp_g[k] == 1) ? 32'h200 : 32'h100);
            check("t2_m0_wait", m_if[0].waitrequest, (exp_g[k] != 0) ? 1 : 0);
            check("t2_m1_wait", m_if[1].waitrequest, (exp_g[k] != 1) ? 1 : 0);
            tick();
            if (k == 3) begin
                m_if[0].read = 1'b0;
                m_if[1].read = 1'b0;
            end
            settle();
            check("t2_arb_gap_read", s_if.read, 0);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            s_if.readdatavalid = 1'b1; s_if.readdata = 16'hA000 + 16'(k);
            settle();
            check("t2_m0_rdv", m_if[0].readdatavalid, (exp_g[k] == 0) ? 1 : 0);
            check("t2_m1_rdv", m_if[1].readdatavalid, (exp_g[k] == 1) ? 1 : 0);
            check("t2_m0_rdata", m_if[0].readdata, 16'hA000 + 16'(k));
            check("t2_m1_rdata", m_if[1].readdata, 16'hA000 + 16'(k));
        end
        tick();
        s_if.readdatavalid = 1'b0;
        settle();
        check("t2_idle_m0_rdv", m_if[0].readdatavalid, 0);
        check("t2_idle_m1_rdv", m_if[1].readdatavalid, 0);

        // 3: m0 reads 0x20, m1 reads 0x30, returns AAAA then BBBB
        tick();
        m_if[0].read = 1'b1; m_if[0].address = 32'h20;
        settle();
        check("t3_arb_read", s_if.read, 0);
        tick();
        settle();
        check("t3_m0_read", s_if.read, 1);
        check("t3_m0_addr", s_if.address, 32'h20);
        check("t3_m0_wait", m_if[0].waitrequest, 0);
        tick();
        m_if[0].read = 1'b0;
        m_if[1].read = 1'b1; m_if[1].address = 32'h30;
        settle();
        check("t3_gap_read", s_if.read, 0);
        tick();
        settle();
        check("t3_m1_read", s_if.read, 1);
        check("t3_m1_addr", s_if.address, 32'h30);
        check("t3_m1_wait", m_if[1].waitrequest, 0);
        check("t3_m0_wait_other", m_if[0].waitrequest, 1);
        tick();
        m_if[1].read = 1'b0;
        settle();
        check("t3_none_m0_rdv", m_if[0].readdatavalid, 0);
        check("t3_none_m1_rdv", m_if[1].readdatavalid, 0);
        tick();
        s_if.readdatavalid = 1'b1; s_if.readdata = 16'hAAAA;
        settle();
        check("t3_beat1_m0_rdv", m_if[0].readdatavalid, 1);
        check("t3_beat1_m1_rdv", m_if[1].readdatavalid, 0);
        check("t3_beat1_data",   m_if[0].readdata, 16'hAAAA);
        tick();
        s_if.readdatavalid = 1'b0;
        settle();
        check("t3_gap_m0_rdv", m_if[0].readdatavalid, 0);
        check("t3_gap_m1_rdv", m_if[1].readdatavalid, 0);
        tick();
        s_if.readdatavalid = 1'b1; s_if.readdata = 16'hBBBB;
        settle();
        check("t3_beat2_m0_rdv", m_if[0].readdatavalid, 0);
        check("t3_beat2_m1_rdv", m_if[1].readdatavalid, 1);
        check("t3_beat2_data",   m_if[1].readdata, 16'hBBBB);
        tick();
        s_if.readdatavalid = 1'b0;
        settle();

        // 4: m1 write held off by slave waitrequest for 5 cycles
        tick();
        m_if[1].write = 1'b1; m_if[1].address = 32'h40; m_if[1].writedata = 16'h5555;
        s_if.waitrequest = 1'b1;
        settle();
        check("t4_arb_write", s_if.write, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 1) begin
                m_if[0].write = 1'b1; m_if[0].address = 32'h50; m_if[0].writedata = 16'h6666;
            end
            settle();
            check("t4_bp_write",   s_if.write, 1);
            check("t4_bp_addr",    s_if.address, 32'h40);
            check("t4_bp_data",    s_if.writedata, 16'h5555);
            check("t4_bp_m1_wait", m_if[1].waitrequest, 1);
            check("t4_bp_m0_wait", m_if[0].waitrequest, 1);
        end
        tick();
        s_if.waitrequest = 1'b0;
        settle();
        check("t4_rel_addr",    s_if.address, 32'h40);
        check("t4_rel_m1_wait", m_if[1].waitrequest, 0);
        check("t4_rel_m0_wait", m_if[0].waitrequest, 1);
        tick();
        m_if[1].write = 1'b0;
        settle();
        check("t4_arb_write2", s_if.write, 0);
        tick();
        settle();
        check("t4_m0_write", s_if.write, 1);
        check("t4_m0_addr",  s_if.address, 32'h50);
        check("t4_m0_data",  s_if.writedata, 16'h6666);
        check("t4_m0_wait",  m_if[0].waitrequest, 0);
        tick();
        m_if[0].write = 1'b0;
        settle();
        check("t4_done_write", s_if.write, 0);

        // 5: owner FIFO full blocks the fifth read until one beat returns
        tick();
        m_if[0].read = 1'b1; m_if[0].address = 32'h60;
        settle();
        for (int k = 0; k < 4; k++) begin
            tick();
            settle();
            check("t5_fill_read", s_if.read, 1);
            tick();
            settle();
        end
        tick();
        settle();
        check("t5_full_read",    s_if.read, 0);
        check("t5_full_m0_wait", m_if[0].waitrequest, 1);
        tick();
        settle();
        check("t5_full_read_held", s_if.read, 0);
        check("t5_full_wait_held", m_if[0].waitrequest, 1);
        tick();
        s_if.readdatavalid = 1'b1; s_if.readdata = 16'h7777;
        settle();
        check("t5_pop_m0_rdv", m_if[0].readdatavalid, 1);
        check("t5_pop_m1_rdv", m_if[1].readdatavalid, 0);
        check("t5_pop_read",   s_if.read, 0);
        tick();
        s_if.readdatavalid = 1'b0;
        settle();
        check("t5_5th_read",    s_if.read, 1);
        check("t5_5th_addr",    s_if.address, 32'h60);
        check("t5_5th_m0_wait", m_if[0].waitrequest, 0);
        tick();
        m_if[0].read = 1'b0;
        settle();
        check("t5_after_read", s_if.read, 0);
        for (int k = 0; k < 2; k++) begin
            tick();
            s_if.readdatavalid = 1'b1; s_if.readdata = 16'h8000 + 16'(k);
            settle();
            check("t5_drain_m0_rdv", m_if[0].readdatavalid, 1);
        end
        tick();
        s_if.readdatavalid = 1'b0;
        settle();
        check("t5_err_clear", dut.r_err, 0);

        // 6: reset with two reads outstanding, then a stray beat
        tick();
        rst_n = 1'b0;
        m_if[1].read = 1'b1; m_if[1].address = 32'h70;
        settle();
        check("t6_rst_read",    s_if.read, 0);
        check("t6_rst_write",   s_if.write, 0);
        check("t6_rst_m0_wait", m_if[0].waitrequest, 1);
        check("t6_rst_m1_wait", m_if[1].waitrequest, 1);
        check("t6_rst_m0_rdv",  m_if[0].readdatavalid, 0);
        check("t6_rst_m1_rdv",  m_if[1].readdatavalid, 0);
        check("t6_rst_err",     dut.r_err, 0);
        tick();
        rst_n = 1'b1;
        m_if[1].read = 1'b0;
        settle();
        tick();
        s_if.readdatavalid = 1'b1; s_if.readdata = 16'hDEAD;
        settle();
        check("t6_stray_m0_rdv", m_if[0].readdatavalid, 0);
        check("t6_stray_m1_rdv", m_if[1].readdatavalid, 0);
        tick();
        s_if.readdatavalid = 1'b0;
        settle();
        check("t6_err_set", dut.r_err, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
